// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard control for the 5-stage pipeline.
// Drives the EX operand mux selects (registered, computed in ID) and the
// combinational stall/bubble/flush controls. Keeps a shadow pipeline of
// destination tags (ID/EX, EX/MEM, MEM/WB).
// Optional: define HAZ_PERF_EN to add saturating performance counters.
module fwd_hazard_ctrl #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             ex_flush,
    input  logic             mem_stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall,
    output logic             bubble,
    output logic             flush
`ifdef HAZ_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt,
    output logic [CNT_W-1:0] perf_fwd_cnt
`endif
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
    } tag_t;

    // A stage supplies reg r only if it really writes it; r0 is never forwarded.
    function automatic logic tag_match(input tag_t t, input logic [REG_W-1:0] r);
        return t.valid & t.regwrite & (t.rd == r) & (r != '0);
    endfunction

    // Youngest writer wins: the ID/EX producer will sit in EX/MEM when the consumer is in EX.
    function automatic logic [1:0] fwd_sel(input logic use_r, input logic [REG_W-1:0] r,
                                           input tag_t idex, input tag_t exmem);
        if (!use_r)                 return 2'b00;
        else if (tag_match(idex, r))  return 2'b01;
        else if (tag_match(exmem, r)) return 2'b10;
        else                        return 2'b00;
    endfunction

    tag_t       idex_q, idex_d;
    tag_t       exmem_q, exmem_d;
    tag_t       memwb_q, memwb_d;
    logic [1:0] fwd_a_q, fwd_a_d;
    logic [1:0] fwd_b_q, fwd_b_d;
    logic       load_use;

    // MEM/WB is tracked for completeness; WB->ID bypass lives in the regfile.
    logic unused_memwb;
    assign unused_memwb = ^memwb_q;

    // Hazard detection, combinational controls and next-state of tags/selects.
    always_comb begin
        load_use = id_valid & idex_q.memread &
                   ((id_use_rs & tag_match(idex_q, id_rs)) |
                    (id_use_rt & tag_match(idex_q, id_rt)));

        stall  = 1'b0;
        bubble = 1'b0;
        flush  = 1'b0;
        if (!rst) begin
            if (mem_stall) begin
                stall = 1'b1;
            end else if (ex_flush) begin
                flush  = 1'b1;
                bubble = 1'b1;
            end else if (load_use) begin
                stall  = 1'b1;
                bubble = 1'b1;
            end
        end

        idex_d  = idex_q;
        exmem_d = exmem_q;
        memwb_d = memwb_q;
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (!mem_stall) begin
            memwb_d = exmem_q;
            exmem_d = idex_q;
            if (id_valid && !ex_flush && !load_use) begin
                idex_d  = '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite, memread: id_memread};
                fwd_a_d = fwd_sel(id_use_rs, id_rs, idex_q, exmem_q);
                fwd_b_d = fwd_sel(id_use_rt, id_rt, idex_q, exmem_q);
            end else begin
                idex_d  = '0;
                fwd_a_d = 2'b00;
                fwd_b_d = 2'b00;
            end
        end
    end

    // Tag shadow pipeline and registered forwarding selects.
    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a = fwd_a_q;
    assign fwd_b = fwd_b_q;

`ifdef HAZ_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
    logic             inc_stall, inc_flush, inc_fwd;

    // Saturating counter increments; nothing counts while the pipe is frozen.
    always_comb begin
        inc_stall   = !mem_stall && !ex_flush && load_use;
        inc_flush   = !mem_stall && ex_flush;
        inc_fwd     = !mem_stall && ((fwd_a_d != 2'b00) || (fwd_b_d != 2'b00));
        stall_cnt_d = (inc_stall && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        flush_cnt_d = (inc_flush && (flush_cnt_q != '1)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
        fwd_cnt_d   = (inc_fwd && (fwd_cnt_q != '1)) ? fwd_cnt_q + 1'b1 : fwd_cnt_q;
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
    assign perf_fwd_cnt   = fwd_cnt_q;
`else
    localparam int unsigned cnt_w_unused = CNT_W;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed self-checking bench for fwd_hazard_ctrl.
// Inputs change just after a rising edge; comb outputs are checked mid-cycle,
// registered selects are checked #1 after the edge that loads them.
module tb_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_use_rs, id_use_rt, id_regwrite, id_memread;
    logic       ex_flush, mem_stall;
    logic [1:0] fwd_a, fwd_b;
    logic       stall, bubble, flush;
`ifdef HAZ_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_fwd_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.REG_W(5), .CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .ex_flush    (ex_flush),
        .mem_stall   (mem_stall),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stall       (stall),
        .bubble      (bubble),
        .flush       (flush)
`ifdef HAZ_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
        .perf_fwd_cnt   (perf_fwd_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Controls packed as {stall, bubble, flush}.
    task automatic chk_ctl(input string tag, input logic [2:0] exp);
        chk(tag, {29'd0, stall, bubble, flush}, {29'd0, exp});
    endtask

    task automatic chk_fwd(input string tag, input logic [1:0] exp_a, input logic [1:0] exp_b);
        chk(tag, {28'd0, fwd_a, fwd_b}, {28'd0, exp_a, exp_b});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic [4:0] rd, input logic rw,
                         input logic mr);
        id_valid    = 1'b1;
        id_rs       = rs;
        id_rt       = rt;
        id_use_rs   = urs;
        id_use_rt   = urt;
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = mr;
        #1;
    endtask

    task automatic nop();
        id_valid    = 1'b0;
        id_use_rs   = 1'b0;
        id_use_rt   = 1'b0;
        id_regwrite = 1'b0;
        id_memread  = 1'b0;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) begin
            nop();
            tick();
        end
    endtask

    initial begin
        ex_flush  = 1'b0;
        mem_stall = 1'b0;
        rst       = 1'b1;

        // Reset with random inputs for two cycles.
        for (int i = 0; i < 2; i++) begin
            id_valid    = 1'($urandom);
            id_rs       = 5'($urandom);
            id_rt       = 5'($urandom);
            id_rd       = 5'($urandom);
            id_use_rs   = 1'($urandom);
            id_use_rt   = 1'($urandom);
            id_regwrite = 1'($urandom);
            id_memread  = 1'($urandom);
            ex_flush    = 1'($urandom);
            mem_stall   = 1'($urandom);
            #1;
            chk_ctl("reset_ctl", 3'b000);
            tick();
            chk_fwd("reset_fwd", 2'b00, 2'b00);
        end
        ex_flush  = 1'b0;
        mem_stall = 1'b0;
        rst       = 1'b0;
`ifdef HAZ_PERF_EN
        chk("reset_perf", perf_stall_cnt | perf_flush_cnt | perf_fwd_cnt, 32'd0);
`endif

        // First instruction after reset sees no forwarding even if the random
        // reset-time inputs looked like producers.
        issue(5'd5, 5'd6, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
        chk_ctl("first_ctl", 3'b000);
        tick();
        chk_fwd("first_fwd", 2'b00, 2'b00);
        drain();
        chk_fwd("drain_fwd", 2'b00, 2'b00);

        // EX->EX on rs.
        issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        issue(5'd5, 5'd3, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        chk_ctl("exex_a_ctl", 3'b000);
        tick();
        chk_fwd("exex_a", 2'b01, 2'b00);
        drain();

        // EX->EX on rt.
        issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        issue(5'd1, 5'd5, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        tick();
        chk_fwd("exex_b", 2'b00, 2'b01);
        drain();

        // MEM->EX on rt across a nop.
        issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        nop();
        tick();
        issue(5'd3, 5'd5, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        tick();
        chk_fwd("memex_b", 2'b00, 2'b10);
        drain();

        // Two writers of r5: youngest wins.
        issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        issue(5'd5, 5'd4, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        tick();
        chk_fwd("youngest", 2'b01, 2'b00);
        drain();

        // Load-use: one stall cycle, then MEM->EX.
        issue(5'd1, 5'd2, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        issue(5'd8, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
        chk_ctl("lu_ctl", 3'b110);
        tick();
        chk_fwd("lu_fwd_cleared", 2'b00, 2'b00);
        chk_ctl("lu_ctl_next", 3'b000);
        tick();
        chk_fwd("lu_fwd", 2'b10, 2'b00);
`ifdef HAZ_PERF_EN
        chk("perf_stall", perf_stall_cnt, 32'd1);
`endif
        drain();

        // r0 is never forwarded.
        issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
        tick();
        issue(5'd0, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        tick();
        chk_fwd("r0", 2'b00, 2'b00);
        drain();

        // Unused source does not cause a load-use stall.
        issue(5'd1, 5'd2, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        issue(5'd8, 5'd3, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0);
        chk_ctl("unused_ctl", 3'b000);
        tick();
        chk_fwd("unused_fwd", 2'b00, 2'b00);
        drain();

        // Flush overrides load-use; the load still advances to EX/MEM.
        issue(5'd1, 5'd2, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        issue(5'd8, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
        ex_flush = 1'b1;
        #1;
        chk_ctl("flush_lu_ctl", 3'b011);
        tick();
        ex_flush = 1'b0;
        chk_fwd("flush_fwd", 2'b00, 2'b00);
        issue(5'd8, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
        chk_ctl("post_flush_ctl", 3'b000);
        tick();
        chk_fwd("post_flush_fwd", 2'b10, 2'b00);
        drain();

        // Freeze mid-forward for three cycles.
        issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        issue(5'd5, 5'd3, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        tick();
        chk_fwd("frz_pre", 2'b01, 2'b00);
        issue(5'd5, 5'd9, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
        mem_stall = 1'b1;
        ex_flush  = 1'b1;
        #1;
        chk_ctl("frz_over_flush", 3'b100);
        ex_flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_ctl("frz_ctl", 3'b100);
            tick();
            chk_fwd("frz_hold", 2'b01, 2'b00);
        end
        mem_stall = 1'b0;
        #1;
        chk_ctl("frz_release_ctl", 3'b000);
        tick();
        chk_fwd("frz_resume", 2'b10, 2'b01);
        drain();

        // Reset during a load-use stall clears it in one edge.
        issue(5'd1, 5'd2, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        issue(5'd8, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
        chk_ctl("rst_mid_pre", 3'b110);
        rst = 1'b1;
        #1;
        chk_ctl("rst_mid_ctl", 3'b000);
        tick();
        rst = 1'b0;
        #1;
        chk_ctl("rst_mid_after", 3'b000);
        tick();
        chk_fwd("rst_mid_fwd", 2'b00, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
